// File: rtl/gcd_pkg.sv
// Shared types and constants for the GCD-core scheduler.
// Holds the FSM state type, the default operand width and the id-width helper.
package gcd_pkg;

  localparam int GCD_W = 16;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    DRAIN = 2'd2,
    RESP  = 2'd3
  } sched_state_t;

  // Requester-index width, never narrower than one bit.
  function automatic int gcd_idw(input int n);
    return (n > 2) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/gcd_sched_if.sv
// Request, response and core-side signals of the shared GCD scheduler.
// The master modport is the client/core side; the slave modport is the scheduler.
interface gcd_sched_if
  import gcd_pkg::*;
#(
  parameter int N_REQ = 4,
  parameter int W     = GCD_W,
  parameter int IDW   = gcd_idw(N_REQ)
);

  logic [N_REQ-1:0]   req_valid;
  logic [N_REQ*W-1:0] req_a;
  logic [N_REQ*W-1:0] req_b;
  logic [N_REQ-1:0]   req_ready;
  logic               rsp_valid;
  logic               rsp_ready;
  logic [IDW-1:0]     rsp_id;
  logic [W-1:0]       rsp_result;
  logic               rsp_err;
  logic               core_start;
  logic [W-1:0]       core_a;
  logic [W-1:0]       core_b;
  logic               core_done;
  logic [W-1:0]       core_result;
  logic               busy;

  modport master (
    output req_valid, req_a, req_b, rsp_ready, core_done, core_result,
    input  req_ready, rsp_valid, rsp_id, rsp_result, rsp_err,
           core_start, core_a, core_b, busy
  );

  modport slave (
    input  req_valid, req_a, req_b, rsp_ready, core_done, core_result,
    output req_ready, rsp_valid, rsp_id, rsp_result, rsp_err,
           core_start, core_a, core_b, busy
  );

endinterface

// File: rtl/gcd_rr_arb.sv
// Combinational round-robin arbiter: first valid requester after ptr, with wrap.
// Zero latency; a grant is only ever produced for a requester whose valid is set.
module gcd_rr_arb #(
  parameter int N_REQ = 4,
  parameter int IDW   = 2
) (
  input  logic [N_REQ-1:0] req_valid,
  input  logic [IDW-1:0]   ptr,
  output logic [N_REQ-1:0] gnt,
  output logic [IDW-1:0]   gnt_idx,
  output logic             gnt_vld
);

  int             j;
  logic [IDW-1:0] cand;

  // Scan farthest-to-nearest so the nearest valid requester after ptr wins.
  always_comb begin
    gnt     = '0;
    gnt_idx = '0;
    gnt_vld = 1'b0;
    j       = 0;
    cand    = '0;
    for (int k = N_REQ; k >= 1; k--) begin
      j    = (int'(ptr) + k) % N_REQ;
      cand = IDW'(j);
      if (req_valid[cand]) begin
        gnt_idx = cand;
        gnt_vld = 1'b1;
      end
    end
    if (gnt_vld) gnt[gnt_idx] = 1'b1;
  end

endmodule

// File: rtl/gcd_sched.sv
// Round-robin sharing of one GCD core; one request in flight, RESP holds under rsp_ready=0.
// GCD_SCHED_ZERO_BYPASS_EN: zero operands answer opA|opB instead of an error response.
module gcd_sched
  import gcd_pkg::*;
#(
  parameter int N_REQ = 4,
  parameter int W     = GCD_W
) (
  input  logic        clk,
  input  logic        rst,
  gcd_sched_if.slave  bus
);

  localparam int IDW = gcd_idw(N_REQ);

  sched_state_t   state_q, state_d;
  logic [IDW-1:0] ptr_q, ptr_d;
  logic [IDW-1:0] id_q, id_d;
  logic [W-1:0]   opa_q, opa_d;
  logic [W-1:0]   opb_q, opb_d;
  logic [W-1:0]   result_q, result_d;
  logic           err_q, err_d;

  logic [N_REQ-1:0] gnt;
  logic [IDW-1:0]   gnt_idx;
  logic             gnt_vld;
  logic [W-1:0]     sel_a, sel_b;

  gcd_rr_arb #(.N_REQ(N_REQ), .IDW(IDW)) u_arb (
    .req_valid (bus.req_valid),
    .ptr       (ptr_q),
    .gnt       (gnt),
    .gnt_idx   (gnt_idx),
    .gnt_vld   (gnt_vld)
  );

  assign sel_a = bus.req_a[int'(gnt_idx) * W +: W];
  assign sel_b = bus.req_b[int'(gnt_idx) * W +: W];

  always_comb begin
    state_d  = state_q;
    ptr_d    = ptr_q;
    id_d     = id_q;
    opa_d    = opa_q;
    opb_d    = opb_q;
    result_d = result_q;
    err_d    = err_q;
    case (state_q)
      IDLE: begin
        if (gnt_vld) begin
          opa_d = sel_a;
          opb_d = sel_b;
          id_d  = gnt_idx;
          ptr_d = gnt_idx;
          if (sel_a != '0 && sel_b != '0) begin
            err_d   = 1'b0;
            state_d = ISSUE;
          end else begin
            // The core never terminates on a zero operand, so it is answered here.
`ifdef GCD_SCHED_ZERO_BYPASS_EN
            result_d = sel_a | sel_b;
            err_d    = 1'b0;
`else
            result_d = '0;
            err_d    = 1'b1;
`endif
            state_d = RESP;
          end
        end
      end
      ISSUE: begin
        if (bus.core_done) begin
          result_d = bus.core_result;
          state_d  = DRAIN;
        end
      end
      // Wait for done to drop so the next start meets an idle core.
      DRAIN: if (!bus.core_done) state_d = RESP;
      RESP:  if (bus.rsp_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      ptr_q    <= IDW'(N_REQ - 1);
      id_q     <= '0;
      opa_q    <= '0;
      opb_q    <= '0;
      result_q <= '0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      ptr_q    <= ptr_d;
      id_q     <= id_d;
      opa_q    <= opa_d;
      opb_q    <= opb_d;
      result_q <= result_d;
      err_q    <= err_d;
    end
  end

  assign bus.req_ready  = (state_q == IDLE && !rst) ? gnt : '0;
  assign bus.rsp_valid  = (state_q == RESP);
  assign bus.rsp_id     = id_q;
  assign bus.rsp_result = result_q;
  assign bus.rsp_err    = err_q;
  assign bus.core_start = (state_q == ISSUE);
  assign bus.core_a     = opa_q;
  assign bus.core_b     = opb_q;
  assign bus.busy       = (state_q != IDLE);

endmodule

// File: tb/tb_gcd_sched.sv
// Directed bench for gcd_sched with a subtractive GCD core model on the core port.
module tb_gcd_sched;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  gcd_sched_if #(.N_REQ(4), .W(16)) bus ();

  gcd_sched #(.N_REQ(4), .W(16)) u_dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  // Core model: loads on start, subtracts to the GCD, holds done until start drops.
  logic [15:0] cx, cy;
  logic        crun;
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      crun            <= 1'b0;
      cx              <= '0;
      cy              <= '0;
      bus.core_done   <= 1'b0;
      bus.core_result <= '0;
    end else if (crun) begin
      if (cx == cy) begin
        crun            <= 1'b0;
        bus.core_done   <= 1'b1;
        bus.core_result <= cx;
      end else if (cx > cy) cx <= cx - cy;
      else cy <= cy - cx;
    end else if (bus.core_done) begin
      if (!bus.core_start) bus.core_done <= 1'b0;
    end else if (bus.core_start) begin
      crun <= 1'b1;
      cx   <= bus.core_a;
      cy   <= bus.core_b;
    end
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int acc_cnt [4] = '{0, 0, 0, 0};
  int acc_id_log[$], acc_cyc_log[$];
  int rsp_id_log[$], rsp_res_log[$], rsp_err_log[$], rsp_cyc_log[$];
  int start_cyc_log[$], done_cyc_log[$];
  logic prev_start = 1'b0, prev_done = 1'b0;

  // Mid-cycle monitor: what is seen here commits at the next rising edge.
  always @(negedge clk) begin
    if (!rst) begin
      for (int i = 0; i < 4; i++) begin
        if (bus.req_valid[i] && bus.req_ready[i]) begin
          acc_cnt[i] <= acc_cnt[i] + 1;
          acc_id_log.push_back(i);
          acc_cyc_log.push_back(cyc);
        end
      end
      if (bus.rsp_valid && bus.rsp_ready) begin
        rsp_id_log.push_back(int'(bus.rsp_id));
        rsp_res_log.push_back(int'(bus.rsp_result));
        rsp_err_log.push_back(int'(bus.rsp_err));
        rsp_cyc_log.push_back(cyc);
      end
      if (bus.core_start && !prev_start) start_cyc_log.push_back(cyc);
      if (bus.core_done && !prev_done) done_cyc_log.push_back(cyc);
    end
    prev_start <= bus.core_start;
    prev_done  <= bus.core_done;
  end

  int passed = 0;
  int total  = 0;
  int want [4];
  int base [4];
  logic [15:0] pa [4];
  logic [15:0] pb [4];

  task automatic step();
    @(posedge clk);
    #1;
    for (int i = 0; i < 4; i++) begin
      bus.req_valid[i]       = (want[i] - (acc_cnt[i] - base[i])) > 0;
      bus.req_a[i*16 +: 16]  = pa[i];
      bus.req_b[i*16 +: 16]  = pb[i];
    end
  endtask

  task automatic do_reset();
    @(posedge clk);
    #1;
    rst           = 1'b1;
    bus.req_valid = '0;
    bus.rsp_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      want[i] = 0;
      pa[i]   = '0;
      pb[i]   = '0;
    end
    repeat (2) @(posedge clk);
    #1;
    for (int i = 0; i < 4; i++) base[i] = acc_cnt[i];
    rst = 1'b0;
  endtask

  task automatic run_until(input int n_target, input string name);
    int k;
    k = 0;
    while (rsp_id_log.size() < n_target && k < 500) begin
      step();
      k++;
    end
    total++;
    if (rsp_id_log.size() < n_target)
      $display("FAIL %s_timeout: got %0d responses want %0d", name, rsp_id_log.size(), n_target);
    else passed++;
  endtask

  task automatic test_reset();
    bus.req_valid = 4'b1111;
    bus.req_a     = '1;
    bus.req_b     = '1;
    bus.rsp_ready = 1'b1;
    repeat (2) @(posedge clk);
    #4;
    total++; if (bus.req_ready !== 4'b0) $display("FAIL rst_req_ready: got %b want 0", bus.req_ready); else passed++;
    total++; if (bus.rsp_valid !== 1'b0) $display("FAIL rst_rsp_valid: got %b want 0", bus.rsp_valid); else passed++;
    total++; if (bus.core_start !== 1'b0) $display("FAIL rst_core_start: got %b want 0", bus.core_start); else passed++;
    total++; if (bus.busy !== 1'b0) $display("FAIL rst_busy: got %b want 0", bus.busy); else passed++;
    total++; if ({bus.rsp_id, bus.rsp_result, bus.rsp_err} !== 19'd0)
      $display("FAIL rst_rsp_fields: got %h want 0", {bus.rsp_id, bus.rsp_result, bus.rsp_err}); else passed++;
    total++; if ({bus.core_a, bus.core_b} !== 32'd0)
      $display("FAIL rst_core_ops: got %h want 0", {bus.core_a, bus.core_b}); else passed++;
    bus.req_valid = '0;
  endtask

  task automatic test_single();
    int r0, a0, s0, d0, k;
    bit seen;
    do_reset();
    r0 = rsp_id_log.size(); a0 = acc_cyc_log.size();
    s0 = start_cyc_log.size(); d0 = done_cyc_log.size();
    pa[0] = 16'd48; pb[0] = 16'd18; want[0] = 1;
    seen = 1'b0; k = 0;
    while (rsp_id_log.size() < r0 + 1 && k < 500) begin
      step();
      #3;
      if (bus.core_start && !seen) begin
        seen = 1'b1;
        total++; if ({bus.core_a, bus.core_b} !== {16'd48, 16'd18})
          $display("FAIL single_core_ops: got %0d,%0d want 48,18", bus.core_a, bus.core_b); else passed++;
      end
      k++;
    end
    total++; if (rsp_id_log.size() < r0 + 1) $display("FAIL single_timeout: got no response want 1"); else passed++;
    repeat (5) step();
    total++; if (rsp_id_log.size() != r0 + 1) $display("FAIL single_count: got %0d responses want 1", rsp_id_log.size() - r0); else passed++;
    total++; if (rsp_id_log[r0] != 0) $display("FAIL single_id: got %0d want 0", rsp_id_log[r0]); else passed++;
    total++; if (rsp_res_log[r0] != 6) $display("FAIL single_result: got %0d want 6", rsp_res_log[r0]); else passed++;
    total++; if (rsp_err_log[r0] != 0) $display("FAIL single_err: got %0d want 0", rsp_err_log[r0]); else passed++;
    total++; if (start_cyc_log[s0] != acc_cyc_log[a0] + 1)
      $display("FAIL single_start_lat: got cycle %0d want %0d", start_cyc_log[s0], acc_cyc_log[a0] + 1); else passed++;
    total++; if (rsp_cyc_log[r0] != done_cyc_log[d0] + 3)
      $display("FAIL single_resp_lat: got cycle %0d want %0d", rsp_cyc_log[r0], done_cyc_log[d0] + 3); else passed++;
  endtask

  task automatic test_all_four();
    int r0, a0;
    int exp_res [4] = '{4, 7, 1, 25};
    do_reset();
    r0 = rsp_id_log.size(); a0 = acc_cyc_log.size();
    pa[0] = 16'd12;  pb[0] = 16'd8;
    pa[1] = 16'd35;  pb[1] = 16'd14;
    pa[2] = 16'd17;  pb[2] = 16'd5;
    pa[3] = 16'd100; pb[3] = 16'd75;
    for (int i = 0; i < 4; i++) want[i] = 1;
    run_until(r0 + 4, "all4");
    for (int i = 0; i < 4; i++) begin
      total++; if (rsp_id_log[r0+i] != i) $display("FAIL all4_id%0d: got %0d want %0d", i, rsp_id_log[r0+i], i); else passed++;
      total++; if (rsp_res_log[r0+i] != exp_res[i])
        $display("FAIL all4_result%0d: got %0d want %0d", i, rsp_res_log[r0+i], exp_res[i]); else passed++;
    end
    total++; if (acc_cyc_log[a0+1] != rsp_cyc_log[r0] + 1)
      $display("FAIL all4_b2b_accept: got cycle %0d want %0d", acc_cyc_log[a0+1], rsp_cyc_log[r0] + 1); else passed++;
  endtask

  task automatic test_alternate();
    int r0, a0;
    do_reset();
    r0 = rsp_id_log.size(); a0 = acc_id_log.size();
    pa[0] = 16'd6; pb[0] = 16'd4; want[0] = 3;
    pa[2] = 16'd9; pb[2] = 16'd6; want[2] = 3;
    run_until(r0 + 6, "alt");
    for (int k = 0; k < 6; k++) begin
      total++; if (acc_id_log[a0+k] != ((k % 2) ? 2 : 0))
        $display("FAIL alt_grant%0d: got %0d want %0d", k, acc_id_log[a0+k], (k % 2) ? 2 : 0); else passed++;
      total++; if (rsp_res_log[r0+k] != ((k % 2) ? 3 : 2))
        $display("FAIL alt_result%0d: got %0d want %0d", k, rsp_res_log[r0+k], (k % 2) ? 3 : 2); else passed++;
    end
  endtask

  task automatic test_zero();
    int r0, a0, s0, exp_res, exp_err;
`ifdef GCD_SCHED_ZERO_BYPASS_EN
    exp_res = 35; exp_err = 0;
`else
    exp_res = 0;  exp_err = 1;
`endif
    do_reset();
    r0 = rsp_id_log.size(); a0 = acc_cyc_log.size(); s0 = start_cyc_log.size();
    pa[1] = 16'd0; pb[1] = 16'd35; want[1] = 1;
    pa[2] = 16'd0; pb[2] = 16'd0;  want[2] = 1;
    run_until(r0 + 2, "zero");
    repeat (3) step();
    total++; if (rsp_id_log[r0] != 1) $display("FAIL zero_id: got %0d want 1", rsp_id_log[r0]); else passed++;
    total++; if (rsp_res_log[r0] != exp_res) $display("FAIL zero_result: got %0d want %0d", rsp_res_log[r0], exp_res); else passed++;
    total++; if (rsp_err_log[r0] != exp_err) $display("FAIL zero_err: got %0d want %0d", rsp_err_log[r0], exp_err); else passed++;
    total++; if (rsp_cyc_log[r0] != acc_cyc_log[a0] + 1)
      $display("FAIL zero_lat: got cycle %0d want %0d", rsp_cyc_log[r0], acc_cyc_log[a0] + 1); else passed++;
    total++; if (rsp_res_log[r0+1] != 0) $display("FAIL zero_both_result: got %0d want 0", rsp_res_log[r0+1]); else passed++;
    total++; if (rsp_err_log[r0+1] != exp_err) $display("FAIL zero_both_err: got %0d want %0d", rsp_err_log[r0+1], exp_err); else passed++;
    total++; if (start_cyc_log.size() != s0)
      $display("FAIL zero_no_start: got %0d core starts want 0", start_cyc_log.size() - s0); else passed++;
  endtask

  task automatic test_backpressure();
    int r0, a0, k;
    do_reset();
    r0 = rsp_id_log.size(); a0 = acc_cyc_log.size();
    bus.rsp_ready = 1'b0;
    pa[0] = 16'd21; pb[0] = 16'd14; want[0] = 1;
    pa[1] = 16'd10; pb[1] = 16'd4;  want[1] = 1;
    k = 0;
    do begin
      step();
      #3;
      k++;
    end while (!bus.rsp_valid && k < 500);
    total++; if (!bus.rsp_valid) $display("FAIL bp_timeout: got no rsp_valid want 1"); else passed++;
    for (int c = 0; c < 10; c++) begin
      step();
      #3;
      total++; if (bus.rsp_valid !== 1'b1) $display("FAIL bp_valid%0d: got %b want 1", c, bus.rsp_valid); else passed++;
      total++; if ({bus.rsp_id, bus.rsp_result} !== {2'd0, 16'd7})
        $display("FAIL bp_stable%0d: got id %0d result %0d want id 0 result 7", c, bus.rsp_id, bus.rsp_result); else passed++;
      total++; if (bus.req_ready !== 4'b0) $display("FAIL bp_req_ready%0d: got %b want 0", c, bus.req_ready); else passed++;
    end
    bus.rsp_ready = 1'b1;
    run_until(r0 + 2, "bp");
    total++; if (acc_cyc_log[a0+1] != rsp_cyc_log[r0] + 1)
      $display("FAIL bp_next_accept: got cycle %0d want %0d", acc_cyc_log[a0+1], rsp_cyc_log[r0] + 1); else passed++;
    total++; if (rsp_id_log[r0+1] != 1 || rsp_res_log[r0+1] != 2)
      $display("FAIL bp_second: got id %0d result %0d want id 1 result 2", rsp_id_log[r0+1], rsp_res_log[r0+1]); else passed++;
  endtask

  task automatic test_reset_mid();
    int r1, a1, k;
    do_reset();
    pa[1] = 16'd270; pb[1] = 16'd192; want[1] = 1;
    k = 0;
    do begin
      step();
      #3;
      k++;
    end while (!bus.core_start && k < 500);
    total++; if (!bus.core_start) $display("FAIL rmid_timeout: got no core_start want 1"); else passed++;
    r1 = rsp_id_log.size();
    rst = 1'b1;
    #1;
    total++; if ({bus.core_start, bus.busy, bus.rsp_valid, bus.rsp_err} !== 4'b0)
      $display("FAIL rmid_ctrl: got %b want 0000", {bus.core_start, bus.busy, bus.rsp_valid, bus.rsp_err}); else passed++;
    total++; if ({bus.core_a, bus.core_b} !== 32'd0)
      $display("FAIL rmid_core_ops: got %h want 0", {bus.core_a, bus.core_b}); else passed++;
    total++; if ({bus.rsp_id, bus.rsp_result} !== 18'd0)
      $display("FAIL rmid_rsp: got id %0d result %0d want 0", bus.rsp_id, bus.rsp_result); else passed++;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    a1 = acc_id_log.size();
    pa[0] = 16'd270; pb[0] = 16'd192; want[0] = 1;
    pa[3] = 16'd3;   pb[3] = 16'd9;   want[3] = 1;
    run_until(r1 + 2, "rmid");
    total++; if (acc_id_log[a1] != 0) $display("FAIL rmid_grant: got %0d want 0", acc_id_log[a1]); else passed++;
    total++; if (rsp_id_log[r1] != 0 || rsp_res_log[r1] != 6)
      $display("FAIL rmid_first: got id %0d result %0d want id 0 result 6", rsp_id_log[r1], rsp_res_log[r1]); else passed++;
    total++; if (rsp_id_log[r1+1] != 3 || rsp_res_log[r1+1] != 3)
      $display("FAIL rmid_second: got id %0d result %0d want id 3 result 3", rsp_id_log[r1+1], rsp_res_log[r1+1]); else passed++;
  endtask

  initial begin
    for (int i = 0; i < 4; i++) begin
      want[i] = 0; base[i] = 0; pa[i] = '0; pb[i] = '0;
    end
    bus.req_valid = '0;
    bus.req_a     = '0;
    bus.req_b     = '0;
    bus.rsp_ready = 1'b1;
    test_reset();
    test_single();
    test_all_four();
    test_alternate();
    test_zero();
    test_backpressure();
    test_reset_mid();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got no completion want finish before time limit");
    $fatal(1);
  end

endmodule
